// File: rtl/dmem_arbiter.sv
// Round-robin arbiter that lets NUM_CORES cores share one synchronous data RAM.
// Each core gets one read or write at a time; read data goes back on a registered broadcast bus.
module dmem_arbiter #(
  parameter int unsigned NUM_CORES   = 4,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CORES-1:0]        core_req,
  input  logic [NUM_CORES-1:0]        core_we,
  input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
  input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
  output logic [NUM_CORES-1:0]        core_gnt,
  output logic [NUM_CORES-1:0]        core_done,
  output logic [DATA_W-1:0]           core_rdata,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  output logic                        mem_we,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic                        busy
);

  localparam int unsigned IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int unsigned CNT_W = 2;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE} state_e;

  state_e                 state_q;
  logic [IDX_W-1:0]       ptr_q;
  logic [IDX_W-1:0]       win_q;
  logic                   wr_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [NUM_CORES-1:0]   gnt_q;
  logic [NUM_CORES-1:0]   done_q;
  logic [DATA_W-1:0]      rdata_q;
  logic [ADDR_W-1:0]      addr_q;
  logic [DATA_W-1:0]      wdata_q;
  logic                   we_q;
  logic                   busy_q;
  logic [IDX_W-1:0]       win_d;
  logic [IDX_W-1:0]       ptr_inc;

  // Scan downward from ptr+N-1 so the requester closest above ptr is written last and wins.
  always_comb begin
    int unsigned scan;
    scan  = 0;
    win_d = ptr_q;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      scan = 32'(ptr_q) + 32'(k);
      if (scan >= NUM_CORES) scan = scan - NUM_CORES;
      if (core_req[IDX_W'(scan)]) win_d = IDX_W'(scan);
    end
  end

  assign ptr_inc = (win_q == IDX_W'(NUM_CORES - 1)) ? '0 : win_q + IDX_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      wr_q    <= 1'b0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      rdata_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      done_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (|core_req) begin
            state_q <= S_ACCESS;
            addr_q  <= core_addr[win_d*ADDR_W +: ADDR_W];
            wdata_q <= core_wdata[win_d*DATA_W +: DATA_W];
            we_q    <= core_we[win_d];
            wr_q    <= core_we[win_d];
            gnt_q   <= NUM_CORES'(1) << win_d;
            win_q   <= win_d;
            busy_q  <= 1'b1;
          end
        end
        S_ACCESS: begin
          we_q  <= 1'b0;
          gnt_q <= '0;
          ptr_q <= ptr_inc;
          if (wr_q) begin
            state_q <= S_DONE;
            done_q  <= NUM_CORES'(1) << win_q;
          end else begin
            state_q <= S_WAIT;
            cnt_q   <= CNT_W'(MEM_LATENCY - 1);
          end
        end
        S_WAIT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            rdata_q <= mem_rdata;
            state_q <= S_DONE;
            done_q  <= NUM_CORES'(1) << win_q;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign core_gnt   = gnt_q;
  assign core_done  = done_q;
  assign core_rdata = rdata_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_we     = we_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: scoreboard of expected grants/completions, plus a MEM_LATENCY=3 instance.
module tb_dmem_arbiter;
  localparam int unsigned NC = 4;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;

  typedef struct {
    int             core;
    bit             rd;
    logic [DW-1:0]  data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [NC-1:0]    core_req, core_we, core_gnt, core_done;
  logic [NC*AW-1:0] core_addr;
  logic [NC*DW-1:0] core_wdata;
  logic [DW-1:0]    core_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0]    mem_addr;
  logic             mem_we, busy;

  logic [NC-1:0]    req3, we3, gnt3, done3;
  logic [NC*AW-1:0] addr3;
  logic [NC*DW-1:0] wdata3;
  logic [DW-1:0]    rdata3, mwdata3, mrdata3;
  logic [AW-1:0]    maddr3;
  logic             mwe3, busy3;

  dmem_arbiter #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .core_req(core_req), .core_we(core_we),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_gnt(core_gnt),
    .core_done(core_done), .core_rdata(core_rdata), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata), .busy(busy)
  );

  dmem_arbiter #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .core_req(req3), .core_we(we3),
    .core_addr(addr3), .core_wdata(wdata3), .core_gnt(gnt3),
    .core_done(done3), .core_rdata(rdata3), .mem_addr(maddr3),
    .mem_wdata(mwdata3), .mem_we(mwe3), .mem_rdata(mrdata3), .busy(busy3)
  );

  // Synchronous RAM models: latency 1 and latency 3 (two extra output stages)
  logic [DW-1:0] ram1 [0:255];
  logic [DW-1:0] ram3 [0:255];
  logic [DW-1:0] q3_p1, q3_p2;
  always @(posedge clk) begin
    if (mem_we) ram1[mem_addr[7:0]] <= mem_wdata;
    mem_rdata <= ram1[mem_addr[7:0]];
  end
  always @(posedge clk) begin
    if (mwe3) ram3[maddr3[7:0]] <= mwdata3;
    q3_p1   <= ram3[maddr3[7:0]];
    q3_p2   <= q3_p1;
    mrdata3 <= q3_p2;
  end

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   gnt_cyc, done_cyc, we_cnt, gnt3_seen, done3_seen, t0;
  int   exp_gnt_q[$];
  exp_t exp_done_q[$];
  logic [NC-1:0] hold;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int c, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    core_we[c]            = w;
    core_addr[c*AW +: AW] = a;
    core_wdata[c*DW +: DW] = d;
    core_req[c]           = 1'b1;
  endtask

  function automatic exp_t mk(input int c, input bit rd, input logic [DW-1:0] d);
    exp_t x;
    x.core = c;
    x.rd   = rd;
    x.data = d;
    return x;
  endfunction

  // One cycle: sample at negedge, score grants/completions, release finished requests.
  task automatic step();
    int   e;
    exp_t x;
    @(negedge clk);
    cyc++;
    if (mem_we) we_cnt++;
    if (core_gnt != '0) begin
      gnt_cyc = cyc;
      if (core_gnt[3]) gnt3_seen++;
      if (exp_gnt_q.size() == 0) chk("gnt_unexpected", 64'(core_gnt), 64'(0));
      else begin
        e = exp_gnt_q.pop_front();
        chk("gnt_order", 64'(core_gnt), 64'(1) << e);
      end
    end
    if (core_done != '0) begin
      done_cyc = cyc;
      if (core_done[3]) done3_seen++;
      if (exp_done_q.size() == 0) chk("done_unexpected", 64'(core_done), 64'(0));
      else begin
        x = exp_done_q.pop_front();
        chk("done_core", 64'(core_done), 64'(1) << x.core);
        if (x.rd) chk("rdata", 64'(core_rdata), 64'(x.data));
      end
      core_req = core_req & ~(core_done & ~hold);
    end
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_gnt_q.size() != 0 || exp_done_q.size() != 0 || busy) && n < 200) begin
      step();
      n++;
      if (exp_gnt_q.size() == 0 && exp_done_q.size() == 0) begin
        core_req = '0;
        hold     = '0;
      end
    end
    chk({tag, "_timeout"}, 64'(n < 200), 64'(1));
  endtask

  task automatic dut3_txn(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          output int n, output int gnt_at);
    we3[0]        = w;
    addr3[AW-1:0] = a;
    wdata3[DW-1:0] = d;
    req3[0]       = 1'b1;
    n = 0;
    gnt_at = 0;
    while (n < 50) begin
      @(negedge clk);
      n++;
      if (gnt3[0] && gnt_at == 0) gnt_at = n;
      if (done3[0]) begin
        req3 = '0;
        break;
      end
    end
  endtask

  initial begin
    int n, g;
    rst_n = 1'b0;
    core_req = '0; core_we = '0; core_addr = '0; core_wdata = '0;
    req3 = '0; we3 = '0; addr3 = '0; wdata3 = '0;
    hold = '0; we_cnt = 0; gnt_cyc = 0; done_cyc = 0; gnt3_seen = 0; done3_seen = 0;
    repeat (2) @(negedge clk);
    chk("rst_gnt",   64'(core_gnt), 64'(0));
    chk("rst_done",  64'(core_done), 64'(0));
    chk("rst_we",    64'(mem_we), 64'(0));
    chk("rst_busy",  64'(busy), 64'(0));
    chk("rst_rdata", 64'(core_rdata), 64'(0));
    chk("rst_addr",  64'(mem_addr), 64'(0));
    chk("rst_wdata", 64'(mem_wdata), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Core 1 write then read back
    set_req(1, 1'b1, 16'h0010, 16'hBEEF);
    exp_gnt_q.push_back(1); exp_done_q.push_back(mk(1, 1'b0, '0));
    we_cnt = 0; t0 = cyc;
    drain("wr1");
    chk("wr1_gnt_lat",  64'(gnt_cyc - t0), 64'(1));
    chk("wr1_done_lat", 64'(done_cyc - t0), 64'(2));
    chk("wr1_we_cycles", 64'(we_cnt), 64'(1));
    set_req(1, 1'b0, 16'h0010, 16'h0000);
    exp_gnt_q.push_back(1); exp_done_q.push_back(mk(1, 1'b1, 16'hBEEF));
    t0 = cyc;
    drain("rd1");
    chk("rd1_done_lat", 64'(done_cyc - t0), 64'(3));

    // Fresh reset, all four cores read at once
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1; @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      set_req(i, 1'b0, 16'h0010, 16'h0000);
      exp_gnt_q.push_back(i); exp_done_q.push_back(mk(i, 1'b1, 16'hBEEF));
    end
    drain("all4");
    set_req(0, 1'b1, 16'h0020, 16'hA000);
    set_req(2, 1'b1, 16'h0022, 16'hA002);
    set_req(3, 1'b1, 16'h0023, 16'hA003);
    for (int i = 0; i < 4; i++) begin
      if (i != 1) begin
        exp_gnt_q.push_back(i); exp_done_q.push_back(mk(i, 1'b0, '0));
      end
    end
    drain("three");

    // Core 1 drops its request during the grant cycle; leaves ptr at 2
    set_req(1, 1'b0, 16'h0022, 16'h0000);
    exp_gnt_q.push_back(1); exp_done_q.push_back(mk(1, 1'b1, 16'hA002));
    step();
    core_req[1] = 1'b0;
    drain("drop_gnt");

    // Cores 2 and 0 hold requests: expect 2,0,2,0
    hold = 4'b0101;
    set_req(2, 1'b0, 16'h0022, 16'h0000);
    set_req(0, 1'b0, 16'h0020, 16'h0000);
    for (int i = 0; i < 2; i++) begin
      exp_gnt_q.push_back(2); exp_done_q.push_back(mk(2, 1'b1, 16'hA002));
      exp_gnt_q.push_back(0); exp_done_q.push_back(mk(0, 1'b1, 16'hA000));
    end
    drain("alt");

    // Core 3 withdraws before it is granted
    gnt3_seen = 0; done3_seen = 0;
    set_req(2, 1'b1, 16'h0024, 16'hC0DE);
    set_req(3, 1'b1, 16'h0025, 16'hDEAD);
    exp_gnt_q.push_back(2); exp_done_q.push_back(mk(2, 1'b0, '0));
    step();
    core_req[3] = 1'b0;
    drain("drop3");
    repeat (4) step();
    chk("drop3_gnt",  64'(gnt3_seen), 64'(0));
    chk("drop3_done", 64'(done3_seen), 64'(0));

    // Reset asserted during the ACCESS cycle of a write
    set_req(0, 1'b1, 16'h0030, 16'h5555);
    exp_gnt_q.push_back(0);
    step();
    chk("rst_mid_we_before", 64'(mem_we), 64'(1));
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_we",   64'(mem_we), 64'(0));
    chk("rst_mid_busy", 64'(busy), 64'(0));
    chk("rst_mid_gnt",  64'(core_gnt), 64'(0));
    core_req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) step();
    set_req(3, 1'b0, 16'h0023, 16'h0000);
    set_req(0, 1'b0, 16'h0020, 16'h0000);
    exp_gnt_q.push_back(0); exp_done_q.push_back(mk(0, 1'b1, 16'hA000));
    exp_gnt_q.push_back(3); exp_done_q.push_back(mk(3, 1'b1, 16'hA003));
    drain("post_rst");

    // MEM_LATENCY=3 instance: seed 0x0005 with a write, then read it
    dut3_txn(1'b1, 16'h0005, 16'h1234, n, g);
    chk("lat3_wr_done", 64'(n), 64'(2));
    @(negedge clk);
    dut3_txn(1'b0, 16'h0005, 16'h0000, n, g);
    chk("lat3_rd_gnt",   64'(g), 64'(1));
    chk("lat3_rd_done",  64'(n), 64'(5));
    chk("lat3_rd_rdata", 64'(rdata3), 64'(16'h1234));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
